// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one 2:1 data mux between two requesters
// Bounded bursts per grant; valid/ready handshake toward a single sink.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_XFER = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          last_owner;
  logic          xfer;
  logic          burst_done;

  assign dout       = sel ? din1 : din0;
  assign dout_valid = (gnt0 & req0) | (gnt1 & req1);
  assign xfer       = dout_valid & dout_ready;
  assign burst_done = xfer && (count == LAST_XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sel        <= 1'b0;
      count      <= '0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the requester that did not own the mux last wins.
          if (req0 && (!req1 || last_owner)) begin
            state <= OWN0;
            gnt0  <= 1'b1;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
          end else if (req1) begin
            state <= OWN1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b1;
            sel   <= 1'b1;
          end
        end
        OWN0: begin
          if (!req0 || burst_done) begin
            last_owner <= 1'b0;
            count      <= '0;
            if (req1) begin
              state <= OWN1;
              gnt0  <= 1'b0;
              gnt1  <= 1'b1;
              sel   <= 1'b1;
            end else begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
              sel   <= 1'b0;
            end
          end else if (xfer) begin
            count <= count + 1'b1;
          end
        end
        OWN1: begin
          if (!req1 || burst_done) begin
            last_owner <= 1'b1;
            count      <= '0;
            if (req0) begin
              state <= OWN0;
              gnt0  <= 1'b1;
              gnt1  <= 1'b0;
              sel   <= 1'b0;
            end else begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
              sel   <= 1'b0;
            end
          end else if (xfer) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          sel   <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
// Two instances: default MAX_BURST=4 and a MAX_BURST=1 build.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, dout_ready;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, sel, dout_valid;
  logic [7:0] dout;

  logic       b_req0, b_req1, b_ready;
  logic [7:0] b_din0, b_din1;
  logic       b_gnt0, b_gnt1, b_sel, b_valid;
  logic [7:0] b_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .din0(b_din0), .din1(b_din1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .sel(b_sel), .dout(b_dout), .dout_valid(b_valid),
    .dout_ready(b_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_owner(input string tag, input logic g0, input logic g1);
    check({tag, "_gnt0"}, 32'(gnt0), 32'(g0));
    check({tag, "_gnt1"}, 32'(gnt1), 32'(g1));
    check({tag, "_sel"},  32'(sel),  32'(g1));
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; dout_ready = 1'b0; din0 = 8'h00; din1 = 8'h00;
    b_req0 = 1'b0; b_req1 = 1'b0; b_ready = 1'b0; b_din0 = 8'h0A; b_din1 = 8'h0B;
    #1;
    check_owner("reset", 1'b0, 1'b0);
    check("reset_valid", 32'(dout_valid), 32'd0);
    step();

    // 1: single requester, 4-transfer burst, 1 idle cycle, regrant
    rst = 1'b0;
    step();
    req0 = 1'b1; dout_ready = 1'b1; din0 = 8'h11; din1 = 8'hEE;
    #1;
    check_owner("t1_latency", 1'b0, 1'b0);
    check("t1_idle_valid", 32'(dout_valid), 32'd0);
    check("t1_idle_dout", 32'(dout), 32'h11);
    for (int i = 0; i < 4; i++) begin
      step();
      din0 = 8'h11 + 8'(i);
      #1;
      check_owner("t1_burst", 1'b1, 1'b0);
      check("t1_valid", 32'(dout_valid), 32'd1);
      check("t1_dout", 32'(dout), 32'(8'h11 + 8'(i)));
    end
    step();
    check_owner("t1_release", 1'b0, 1'b0);
    check("t1_release_valid", 32'(dout_valid), 32'd0);
    step();
    check_owner("t1_regrant", 1'b1, 1'b0);

    // 2: both requesting from reset, alternate every 4 with no idle bubble
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; din0 = 8'hA0; din1 = 8'h5B;
    step();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic own1;
      step();
      own1 = ((k / 4) % 2) == 1;
      check_owner("t2_rr", !own1, own1);
      check("t2_dout", 32'(dout), own1 ? 32'h5B : 32'hA0);
    end

    // 3: backpressure in OWN1 at count=2
    rst = 1'b1; req0 = 1'b0; req1 = 1'b1; dout_ready = 1'b1; din1 = 8'h3C;
    step();
    rst = 1'b0;
    step();
    check_owner("t3_own1", 1'b0, 1'b1);
    step();
    step();
    dout_ready = 1'b0; req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_owner("t3_hold", 1'b0, 1'b1);
      check("t3_dout", 32'(dout), 32'h3C);
      check("t3_valid", 32'(dout_valid), 32'd1);
    end
    dout_ready = 1'b1;
    #1;
    check_owner("t3_xfer3", 1'b0, 1'b1);
    step();
    check_owner("t3_xfer4", 1'b0, 1'b1);
    step();
    check_owner("t3_handover", 1'b1, 1'b0);

    // 4: req0 drops after one transfer, no competitor -> IDLE; tie then goes to req1
    req1 = 1'b0;
    step();
    check_owner("t4_own0", 1'b1, 1'b0);
    req0 = 1'b0;
    #1;
    check("t4_valid_drop", 32'(dout_valid), 32'd0);
    step();
    check_owner("t4_idle", 1'b0, 1'b0);
    check("t4_idle_valid", 32'(dout_valid), 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    step();
    check_owner("t4_tie_req1", 1'b0, 1'b1);

    // 6: async reset mid-burst (OWN1, count=3)
    step();
    step();
    step();
    check_owner("t6_own1_c3", 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_owner("t6_async", 1'b0, 1'b0);
    check("t6_async_valid", 32'(dout_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_owner("t6_tie_req0", 1'b1, 1'b0);

    // 5: MAX_BURST=1 strict alternation
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    b_req0 = 1'b1; b_req1 = 1'b1; b_ready = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t5_gnt0", 32'(b_gnt0), 32'((k % 2) == 0));
      check("t5_gnt1", 32'(b_gnt1), 32'((k % 2) == 1));
      check("t5_dout", 32'(b_dout), (k % 2) == 1 ? 32'h0B : 32'h0A);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
